// File: rtl/chess_clock_ctrl.sv
// rtl/chess_clock_ctrl.sv - turn-control FSM for a two-player countdown chess timer
module chess_clock_ctrl #(
    parameter logic [5:0] MIN_TIME     = 6'd1,
    parameter logic [5:0] MAX_TIME     = 6'd60,
    parameter logic [5:0] DEFAULT_TIME = 6'd5,
    parameter logic [5:0] STEP         = 6'd1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_up,
    input  logic       btn_p1,
    input  logic       btn_p2,
    input  logic [5:0] min_p1,
    input  logic [5:0] sec_p1,
    input  logic [5:0] min_p2,
    input  logic [5:0] sec_p2,
    output logic       en_p1,
    output logic       en_p2,
    output logic       clr,
    output logic [5:0] time_sel,
    output logic       flag_p1,
    output logic       flag_p2,
    output logic       turn,
    output logic       paused,
    output logic [7:0] move_count
);

    typedef enum logic [2:0] {
        SETUP,
        ARM,
        RUN_P1,
        RUN_P2,
        PAUSED,
        FLAG
    } state_t;

    state_t     state;
    logic       armed_p1;
    logic       armed_p2;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] sync3;
    logic [3:0] pulse;
    logic       start_pulse;
    logic       up_pulse;
    logic       p1_pulse;
    logic       p2_pulse;
    logic       timeout_p1;
    logic       timeout_p2;
    logic [6:0] time_sum;
    logic [5:0] time_next;

    // Two-flop synchronizer plus a third flop for rising-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= {btn_start, btn_up, btn_p1, btn_p2};
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign pulse       = sync2 & ~sync3;
    assign start_pulse = pulse[3];
    assign up_pulse    = pulse[2];
    assign p1_pulse    = pulse[1];
    assign p2_pulse    = pulse[0];

    assign timeout_p1 = (state == RUN_P1) && armed_p1 && (min_p1 == 6'd0) && (sec_p1 == 6'd0);
    assign timeout_p2 = (state == RUN_P2) && armed_p2 && (min_p2 == 6'd0) && (sec_p2 == 6'd0);

    // Enable drops combinationally at 0:00 so the counter never reloads its preset.
    assign en_p1  = (state == ARM) || ((state == RUN_P1) && !timeout_p1);
    assign en_p2  = (state == ARM) || ((state == RUN_P2) && !timeout_p2);
    assign clr    = (state == SETUP);
    assign paused = (state == PAUSED);

    assign time_sum  = {1'b0, time_sel} + {1'b0, STEP};
    assign time_next = (time_sum > {1'b0, MAX_TIME}) ? MIN_TIME : time_sum[5:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SETUP;
            time_sel   <= DEFAULT_TIME;
            flag_p1    <= 1'b0;
            flag_p2    <= 1'b0;
            turn       <= 1'b0;
            move_count <= 8'd0;
            armed_p1   <= 1'b0;
            armed_p2   <= 1'b0;
        end else begin
            case (state)
                SETUP: begin
                    flag_p1  <= 1'b0;
                    flag_p2  <= 1'b0;
                    armed_p1 <= 1'b0;
                    armed_p2 <= 1'b0;
                    if (up_pulse)
                        time_sel <= time_next;
                    if (start_pulse)
                        state <= ARM;
                end
                ARM: begin
                    flag_p1    <= 1'b0;
                    flag_p2    <= 1'b0;
                    armed_p1   <= 1'b0;
                    armed_p2   <= 1'b0;
                    move_count <= 8'd0;
                    turn       <= 1'b0;
                    state      <= RUN_P1;
                end
                RUN_P1: begin
                    if ((min_p1 != 6'd0) || (sec_p1 != 6'd0))
                        armed_p1 <= 1'b1;
                    if (timeout_p1) begin
                        state   <= FLAG;
                        flag_p1 <= 1'b1;
                    end else if (start_pulse) begin
                        state <= PAUSED;
                    end else if (p1_pulse) begin
                        state <= RUN_P2;
                        turn  <= 1'b1;
                        if (move_count != 8'hff)
                            move_count <= move_count + 8'd1;
                    end
                end
                RUN_P2: begin
                    if ((min_p2 != 6'd0) || (sec_p2 != 6'd0))
                        armed_p2 <= 1'b1;
                    if (timeout_p2) begin
                        state   <= FLAG;
                        flag_p2 <= 1'b1;
                    end else if (start_pulse) begin
                        state <= PAUSED;
                    end else if (p2_pulse) begin
                        state <= RUN_P1;
                        turn  <= 1'b0;
                        if (move_count != 8'hff)
                            move_count <= move_count + 8'd1;
                    end
                end
                PAUSED: begin
                    // turn always names the side that was running, so it doubles as the resume target.
                    if (start_pulse)
                        state <= turn ? RUN_P2 : RUN_P1;
                end
                FLAG: begin
                    if (start_pulse) begin
                        state   <= SETUP;
                        flag_p1 <= 1'b0;
                        flag_p2 <= 1'b0;
                    end
                end
                default: state <= SETUP;
            endcase
        end
    end

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// tb/tb_chess_clock_ctrl.sv - directed self-checking bench for chess_clock_ctrl
module tb_chess_clock_ctrl;

    logic       clk;
    logic       reset_n;
    logic       btn_start;
    logic       btn_up;
    logic       btn_p1;
    logic       btn_p2;
    logic [5:0] min_p1;
    logic [5:0] sec_p1;
    logic [5:0] min_p2;
    logic [5:0] sec_p2;
    logic       en_p1;
    logic       en_p2;
    logic       clr;
    logic [5:0] time_sel;
    logic       flag_p1;
    logic       flag_p2;
    logic       turn;
    logic       paused;
    logic [7:0] move_count;

    int checks;
    int failures;

    chess_clock_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_start  (btn_start),
        .btn_up     (btn_up),
        .btn_p1     (btn_p1),
        .btn_p2     (btn_p2),
        .min_p1     (min_p1),
        .sec_p1     (sec_p1),
        .min_p2     (min_p2),
        .sec_p2     (sec_p2),
        .en_p1      (en_p1),
        .en_p2      (en_p2),
        .clr        (clr),
        .time_sel   (time_sel),
        .flag_p1    (flag_p1),
        .flag_p2    (flag_p2),
        .turn       (turn),
        .paused     (paused),
        .move_count (move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_start = v;
            1: btn_up    = v;
            2: btn_p1    = v;
            default: btn_p2 = v;
        endcase
    endtask

    // Action lands on the third edge after the rising input.
    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick(3);
        set_btn(b, 1'b0);
        tick(3);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        btn_start = 1'b0;
        btn_up    = 1'b0;
        btn_p1    = 1'b0;
        btn_p2    = 1'b0;
        min_p1    = 6'd0;
        sec_p1    = 6'd0;
        min_p2    = 6'd0;
        sec_p2    = 6'd0;
        tick(3);
        check("rst_time_sel", 32'(time_sel), 32'd5);
        check("rst_clr", 32'(clr), 32'd1);
        check("rst_en_p1", 32'(en_p1), 32'd0);
        check("rst_en_p2", 32'(en_p2), 32'd0);
        check("rst_flags", 32'({flag_p1, flag_p2}), 32'd0);
        check("rst_turn", 32'(turn), 32'd0);
        check("rst_paused", 32'(paused), 32'd0);
        check("rst_moves", 32'(move_count), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Preset selection and wrap at MAX_TIME.
        for (int i = 0; i < 3; i++) press(1);
        check("up_to_8", 32'(time_sel), 32'd8);
        for (int i = 0; i < 52; i++) press(1);
        check("up_to_60", 32'(time_sel), 32'd60);
        press(1);
        check("wrap_to_1", 32'(time_sel), 32'd1);
        for (int i = 0; i < 7; i++) press(1);
        check("back_to_8", 32'(time_sel), 32'd8);

        // Start: one ARM cycle then RUN_P1.
        btn_start = 1'b1;
        tick(2);
        check("pre_arm_clr", 32'(clr), 32'd1);
        check("pre_arm_en", 32'({en_p1, en_p2}), 32'd0);
        tick(1);
        check("arm_en", 32'({en_p1, en_p2}), 32'd3);
        check("arm_clr", 32'(clr), 32'd0);
        min_p1 = 6'd8;
        min_p2 = 6'd8;
        tick(1);
        check("run1_en", 32'({en_p1, en_p2}), 32'd2);
        check("run1_turn", 32'(turn), 32'd0);
        check("run1_clr", 32'(clr), 32'd0);
        btn_start = 1'b0;
        tick(3);

        // Turn switching; wrong player's button ignored, held button counts once.
        press(3);
        check("p2_ignored_turn", 32'(turn), 32'd0);
        check("p2_ignored_moves", 32'(move_count), 32'd0);
        press(2);
        check("sw1_en", 32'({en_p1, en_p2}), 32'd1);
        check("sw1_turn", 32'(turn), 32'd1);
        check("sw1_moves", 32'(move_count), 32'd1);
        btn_p2 = 1'b1;
        tick(100);
        check("hold_turn", 32'(turn), 32'd0);
        check("hold_moves", 32'(move_count), 32'd2);
        btn_p2 = 1'b0;
        tick(3);
        press(2);
        check("sw3_moves", 32'(move_count), 32'd3);

        // Pause and resume from RUN_P2.
        press(0);
        check("pause_flag", 32'(paused), 32'd1);
        check("pause_en", 32'({en_p1, en_p2}), 32'd0);
        press(2);
        check("pause_p1_ignored", 32'(paused), 32'd1);
        check("pause_turn", 32'(turn), 32'd1);
        check("pause_moves", 32'(move_count), 32'd3);
        press(0);
        check("resume_paused", 32'(paused), 32'd0);
        check("resume_en", 32'({en_p1, en_p2}), 32'd1);
        press(3);
        check("sw4_moves", 32'(move_count), 32'd4);

        // Timeout for player 1.
        min_p1 = 6'd0;
        sec_p1 = 6'd1;
        tick(1);
        check("t01_en_p1", 32'(en_p1), 32'd1);
        sec_p1 = 6'd0;
        #1;
        check("t00_en_p1_same_cycle", 32'(en_p1), 32'd0);
        check("t00_no_flag_yet", 32'(flag_p1), 32'd0);
        tick(1);
        check("flag_p1_set", 32'(flag_p1), 32'd1);
        check("flag_p2_clear", 32'(flag_p2), 32'd0);
        tick(5);
        check("flag_en_held_off", 32'({en_p1, en_p2}), 32'd0);
        check("flag_turn_held", 32'(turn), 32'd0);
        press(0);
        check("setup_clr", 32'(clr), 32'd1);
        check("setup_flag_clear", 32'(flag_p1), 32'd0);
        check("setup_time_kept", 32'(time_sel), 32'd8);

        // New game, simultaneous p1 and start: start wins.
        btn_start = 1'b1;
        tick(3);
        min_p1 = 6'd8;
        tick(1);
        btn_start = 1'b0;
        tick(3);
        check("game2_moves", 32'(move_count), 32'd0);
        check("game2_en", 32'({en_p1, en_p2}), 32'd2);
        btn_p1    = 1'b1;
        btn_start = 1'b1;
        tick(3);
        check("prio_paused", 32'(paused), 32'd1);
        check("prio_turn", 32'(turn), 32'd0);
        check("prio_moves", 32'(move_count), 32'd0);
        btn_p1    = 1'b0;
        btn_start = 1'b0;
        tick(3);
        press(0);
        press(2);
        check("game2_turn", 32'(turn), 32'd1);
        press(1);
        check("time_frozen", 32'(time_sel), 32'd8);

        // Async reset mid-RUN_P2.
        tick(2);
        reset_n = 1'b0;
        #1;
        check("async_clr", 32'(clr), 32'd1);
        check("async_en", 32'({en_p1, en_p2}), 32'd0);
        check("async_turn", 32'(turn), 32'd0);
        check("async_moves", 32'(move_count), 32'd0);
        check("async_time_sel", 32'(time_sel), 32'd5);
        check("async_paused", 32'(paused), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
